pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage 16-bit pipeline.
// Produces write enables and bubble-insert flushes for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB. Handles dmem stalls (with timeout), MEM-resolved
// redirects, load-use hazards, imem stalls and the halt drain sequence.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT   = 64,
    parameter int DRAIN_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ifid_rs,
    input  logic [2:0] ifid_rt,
    input  logic       ifid_rs_used,
    input  logic       ifid_rt_used,
    input  logic       idex_MemRead,
    input  logic       idex_wreg_flag,
    input  logic [2:0] idex_reg_to_write,
    input  logic       exmem_memen,
    input  logic       dmem_stall,
    input  logic       imem_stall,
    input  logic       exmem_redirect,
    input  logic       exmem_HaltRaw,
    output logic       pc_wen,
    output logic       ifid_wen,
    output logic       idex_wen,
    output logic       exmem_wen,
    output logic       memwb_wen,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       halted,
    output logic       err,
    output logic [1:0] state
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam int DCW = $clog2(DRAIN_CYC) + 1;
    localparam logic [WCW-1:0] WAIT_MAX   = WCW'(TIMEOUT);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t         cur_state, nxt_state;
    logic [WCW-1:0] wait_cnt, wait_nxt;
    logic [DCW-1:0] drain_cnt, drain_nxt;
    logic           halted_r, halted_nxt;
    logic           err_r, err_nxt;
    logic           load_use;

    // A load in EX feeding a register the ID instruction actually reads
    assign load_use = idex_MemRead & idex_wreg_flag &
                      ((ifid_rs_used & (ifid_rs == idex_reg_to_write)) |
                       (ifid_rt_used & (ifid_rt == idex_reg_to_write)));

    assign state  = cur_state;
    assign halted = halted_r;
    assign err    = err_r;

    // State and counter registers; reset returns to RUN immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            halted_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            halted_r  <= halted_nxt;
            err_r     <= err_nxt;
        end
    end

    // Next-state and output decode; the normal-flow priority rules are shared
    // by RUN and by the release cycle of WAIT
    always_comb begin
        logic apply_run;
        apply_run   = 1'b0;
        nxt_state   = cur_state;
        wait_nxt    = wait_cnt;
        drain_nxt   = drain_cnt;
        halted_nxt  = halted_r;
        err_nxt     = err_r;
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exmem_wen   = 1'b0;
        memwb_wen   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        case (cur_state)
            ST_RUN: begin
                if (exmem_memen & dmem_stall) begin
                    nxt_state = ST_WAIT;
                    wait_nxt  = WCW'(1);
                end else begin
                    apply_run = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem_stall) begin
                    if (wait_cnt == WAIT_MAX) begin
                        nxt_state = ST_STOP;
                        err_nxt   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    apply_run = 1'b1;
                    wait_nxt  = '0;
                    nxt_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                pc_wen      = 1'b0;
                ifid_wen    = 1'b1;
                idex_wen    = 1'b1;
                exmem_wen   = 1'b1;
                memwb_wen   = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                drain_nxt   = drain_cnt + 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    nxt_state  = ST_STOP;
                    halted_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (apply_run) begin
            if (exmem_HaltRaw) begin
                ifid_wen    = 1'b1;
                idex_wen    = 1'b1;
                exmem_wen   = 1'b1;
                memwb_wen   = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                nxt_state   = ST_DRAIN;
                drain_nxt   = '0;
            end else if (exmem_redirect) begin
                pc_wen      = 1'b1;
                ifid_wen    = 1'b1;
                idex_wen    = 1'b1;
                exmem_wen   = 1'b1;
                memwb_wen   = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                idex_wen    = 1'b1;
                exmem_wen   = 1'b1;
                memwb_wen   = 1'b1;
                idex_flush  = 1'b1;
            end else if (imem_stall) begin
                ifid_wen    = 1'b1;
                idex_wen    = 1'b1;
                exmem_wen   = 1'b1;
                memwb_wen   = 1'b1;
                ifid_flush  = 1'b1;
            end else begin
                pc_wen      = 1'b1;
                ifid_wen    = 1'b1;
                idex_wen    = 1'b1;
                exmem_wen   = 1'b1;
                memwb_wen   = 1'b1;
            end
        end

        if (rst) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_wen    = 1'b0;
            exmem_wen   = 1'b0;
            memwb_wen   = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a cycle-level reference model of
// the hazard controller, plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT   = 4;
    localparam int DRAIN_CYC = 2;

    // Output vector order: pc, ifid, idex, exmem, memwb wen, then ifid/idex/exmem flush
    localparam logic [7:0] V_NONE   = 8'b00000_000;
    localparam logic [7:0] V_NORM   = 8'b11111_000;
    localparam logic [7:0] V_HALT   = 8'b01111_111;
    localparam logic [7:0] V_REDIR  = 8'b11111_111;
    localparam logic [7:0] V_LOADU  = 8'b00111_010;
    localparam logic [7:0] V_IMEM   = 8'b01111_100;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       mem_read;
        logic       wreg;
        logic [2:0] rd;
        logic       memen;
        logic       dstall;
        logic       istall;
        logic       redirect;
        logic       halt;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] ifid_rs = '0;
    logic [2:0] ifid_rt = '0;
    logic       ifid_rs_used = 1'b0;
    logic       ifid_rt_used = 1'b0;
    logic       idex_MemRead = 1'b0;
    logic       idex_wreg_flag = 1'b0;
    logic [2:0] idex_reg_to_write = '0;
    logic       exmem_memen = 1'b0;
    logic       dmem_stall = 1'b0;
    logic       imem_stall = 1'b0;
    logic       exmem_redirect = 1'b0;
    logic       exmem_HaltRaw = 1'b0;
    logic       pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic       halted, err;
    logic [1:0] state;
    logic [7:0] outv;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode 0 run, 1 wait, 2 drain, 3 stop
    int   m_mode = 0;
    int   m_wait = 0;
    int   m_drain = 0;
    logic m_halted = 1'b0;
    logic m_err = 1'b0;

    assign outv = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                   ifid_flush, idex_flush, exmem_flush};

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk               (clk),
        .rst               (rst),
        .ifid_rs           (ifid_rs),
        .ifid_rt           (ifid_rt),
        .ifid_rs_used      (ifid_rs_used),
        .ifid_rt_used      (ifid_rt_used),
        .idex_MemRead      (idex_MemRead),
        .idex_wreg_flag    (idex_wreg_flag),
        .idex_reg_to_write (idex_reg_to_write),
        .exmem_memen       (exmem_memen),
        .dmem_stall        (dmem_stall),
        .imem_stall        (imem_stall),
        .exmem_redirect    (exmem_redirect),
        .exmem_HaltRaw     (exmem_HaltRaw),
        .pc_wen            (pc_wen),
        .ifid_wen          (ifid_wen),
        .idex_wen          (idex_wen),
        .exmem_wen         (exmem_wen),
        .memwb_wen         (memwb_wen),
        .ifid_flush        (ifid_flush),
        .idex_flush        (idex_flush),
        .exmem_flush       (exmem_flush),
        .halted            (halted),
        .err               (err),
        .state             (state)
    );

    always #5 clk = ~clk;

    // Single comparison point used by the model and the directed checks
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Drive one cycle's inputs just after the active edge
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        ifid_rs           = s.rs;
        ifid_rt           = s.rt;
        ifid_rs_used      = s.rs_used;
        ifid_rt_used      = s.rt_used;
        idex_MemRead      = s.mem_read;
        idex_wreg_flag    = s.wreg;
        idex_reg_to_write = s.rd;
        exmem_memen       = s.memen;
        dmem_stall        = s.dstall;
        imem_stall        = s.istall;
        exmem_redirect    = s.redirect;
        exmem_HaltRaw     = s.halt;
        #1;
    endtask

    // Reset pulse spanning one falling edge; outputs must drop without a clock edge
    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        {ifid_rs, ifid_rt, ifid_rs_used, ifid_rt_used, idex_MemRead, idex_wreg_flag,
         idex_reg_to_write, exmem_memen, dmem_stall, imem_stall, exmem_redirect, exmem_HaltRaw} = '0;
        #1;
        checkOutput("rst_async_outs", 32'(outv), 32'(V_NONE));
        checkOutput("rst_async_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Normal-flow priority outcome for the present inputs
    function automatic logic [7:0] runRules();
        logic hit;
        hit = idex_MemRead && idex_wreg_flag &&
              ((ifid_rs_used && ifid_rs == idex_reg_to_write) ||
               (ifid_rt_used && ifid_rt == idex_reg_to_write));
        if (exmem_HaltRaw)  return V_HALT;
        if (exmem_redirect) return V_REDIR;
        if (hit)            return V_LOADU;
        if (imem_stall)     return V_IMEM;
        return V_NORM;
    endfunction

    // Model clears as soon as reset rises
    always @(posedge rst) begin
        m_mode = 0; m_wait = 0; m_drain = 0; m_halted = 1'b0; m_err = 1'b0;
    end

    // Per-cycle comparison on the falling edge, then advance the model
    always @(negedge clk) begin
        logic [7:0] exp_v;
        int   n_mode, n_wait, n_drain;
        logic n_halted, n_err;
        n_mode = m_mode; n_wait = m_wait; n_drain = m_drain;
        n_halted = m_halted; n_err = m_err;
        exp_v = V_NONE;
        if (rst) begin
            n_mode = 0; n_wait = 0; n_drain = 0; n_halted = 1'b0; n_err = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (exmem_memen && dmem_stall) begin
                        n_mode = 1; n_wait = 1;
                    end else begin
                        exp_v = runRules();
                        if (exmem_HaltRaw) begin n_mode = 2; n_drain = 0; end
                    end
                end
                1: begin
                    if (dmem_stall) begin
                        if (m_wait == TIMEOUT) begin n_mode = 3; n_err = 1'b1; end
                        else n_wait = m_wait + 1;
                    end else begin
                        exp_v = runRules();
                        n_wait = 0;
                        n_mode = exmem_HaltRaw ? 2 : 0;
                        n_drain = 0;
                    end
                end
                2: begin
                    exp_v = V_HALT;
                    n_drain = m_drain + 1;
                    if (m_drain == DRAIN_CYC - 1) begin n_mode = 3; n_halted = 1'b1; end
                end
                default: exp_v = V_NONE;
            endcase
        end
        checkOutput("model_outs", 32'(outv), 32'(exp_v));
        checkOutput("model_state", 32'(state), 32'(rst ? 0 : m_mode));
        checkOutput("model_halted", 32'(halted), 32'(rst ? 1'b0 : m_halted));
        checkOutput("model_err", 32'(err), 32'(rst ? 1'b0 : m_err));
        m_mode = n_mode; m_wait = n_wait; m_drain = n_drain;
        m_halted = n_halted; m_err = n_err;
    end

    initial begin
        stim_t s;
        doReset();

        // Idle after reset
        s = '0;
        applyStimulus(s);
        checkOutput("idle_outs", 32'(outv), 32'(V_NORM));
        checkOutput("idle_state", 32'(state), 32'd0);
        checkOutput("idle_flags", 32'({halted, err}), 32'd0);

        // Load-use on rs beats imem_stall; IF/ID held, not flushed
        s = '0; s.mem_read = 1; s.wreg = 1; s.rd = 3; s.rs = 3; s.rs_used = 1; s.istall = 1;
        applyStimulus(s);
        checkOutput("loaduse_rs", 32'(outv), 32'(V_LOADU));
        s.rs_used = 0; s.istall = 0;
        applyStimulus(s);
        checkOutput("loaduse_rs_unused", 32'(outv), 32'(V_NORM));
        s = '0; s.mem_read = 1; s.wreg = 1; s.rd = 5; s.rt = 5; s.rt_used = 1;
        applyStimulus(s);
        checkOutput("loaduse_rt", 32'(outv), 32'(V_LOADU));
        s.wreg = 0;
        applyStimulus(s);
        checkOutput("loaduse_nowreg", 32'(outv), 32'(V_NORM));
        s = '0; s.istall = 1;
        applyStimulus(s);
        checkOutput("imem_stall", 32'(outv), 32'(V_IMEM));

        // Redirect overrides a simultaneous load-use
        s = '0; s.mem_read = 1; s.wreg = 1; s.rd = 2; s.rs = 2; s.rs_used = 1; s.redirect = 1; s.istall = 1;
        applyStimulus(s);
        checkOutput("redirect_loaduse", 32'(outv), 32'(V_REDIR));

        // Three-cycle dmem stall
        s = '0; s.memen = 1; s.dstall = 1;
        applyStimulus(s);
        checkOutput("dstall_c1_outs", 32'(outv), 32'(V_NONE));
        checkOutput("dstall_c1_state", 32'(state), 32'd0);
        applyStimulus(s);
        checkOutput("dstall_c2_state", 32'(state), 32'd1);
        applyStimulus(s);
        checkOutput("dstall_c3_outs", 32'(outv), 32'(V_NONE));
        s.dstall = 0;
        applyStimulus(s);
        checkOutput("dstall_release_outs", 32'(outv), 32'(V_NORM));
        checkOutput("dstall_release_state", 32'(state), 32'd1);
        s = '0;
        applyStimulus(s);
        checkOutput("dstall_back_state", 32'(state), 32'd0);

        // Timeout: TIMEOUT stalled cycles tolerated, the next one errors
        s = '0; s.memen = 1; s.dstall = 1;
        for (int i = 0; i < 5; i++) applyStimulus(s);
        checkOutput("timeout_edge_state", 32'(state), 32'd1);
        checkOutput("timeout_edge_err", 32'(err), 32'd0);
        s.dstall = 0;
        applyStimulus(s);
        checkOutput("timeout_state", 32'(state), 32'd3);
        checkOutput("timeout_err", 32'(err), 32'd1);
        s = '0; s.redirect = 1;
        applyStimulus(s);
        checkOutput("timeout_sticky_err", 32'(err), 32'd1);
        checkOutput("stop_ignores_inputs", 32'(outv), 32'(V_NONE));
        doReset();
        checkOutput("err_cleared", 32'(err), 32'd0);

        // Reset in the middle of WAIT
        s = '0; s.memen = 1; s.dstall = 1;
        applyStimulus(s);
        applyStimulus(s);
        checkOutput("midwait_state", 32'(state), 32'd1);
        doReset();

        // Halt drain
        s = '0; s.halt = 1;
        applyStimulus(s);
        checkOutput("halt_outs", 32'(outv), 32'(V_HALT));
        s = '0;
        applyStimulus(s);
        checkOutput("drain1_state", 32'(state), 32'd2);
        checkOutput("drain1_outs", 32'(outv), 32'(V_HALT));
        applyStimulus(s);
        checkOutput("drain2_outs", 32'(outv), 32'(V_HALT));
        applyStimulus(s);
        checkOutput("halted_state", 32'(state), 32'd3);
        checkOutput("halted_flag", 32'(halted), 32'd1);
        checkOutput("halted_outs", 32'(outv), 32'(V_NONE));
        doReset();

        // Halt arriving under a dmem stall waits first
        s = '0; s.memen = 1; s.dstall = 1; s.halt = 1;
        applyStimulus(s);
        checkOutput("halt_stall_outs", 32'(outv), 32'(V_NONE));
        applyStimulus(s);
        s.dstall = 0;
        applyStimulus(s);
        checkOutput("halt_release_outs", 32'(outv), 32'(V_HALT));
        checkOutput("halt_release_state", 32'(state), 32'd1);
        s = '0;
        applyStimulus(s);
        checkOutput("halt_wait_drain", 32'(state), 32'd2);
        applyStimulus(s);
        applyStimulus(s);
        checkOutput("halt_wait_halted", 32'(halted), 32'd1);

        // Reset in the middle of DRAIN
        doReset();
        s = '0; s.halt = 1;
        applyStimulus(s);
        s = '0;
        applyStimulus(s);
        checkOutput("middrain_state", 32'(state), 32'd2);
        doReset();
        applyStimulus(s);
        checkOutput("post_reset_outs", 32'(outv), 32'(V_NORM));

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
